// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents:
//   md_state_e  : MULT/DIV tracker state encoding (MD_IDLE=0, MD_RUN=1)
//   pipe_ctl_t  : bundle of pipeline-register enables/flushes
//   CTL_*       : the four prioritised control patterns
//   DEF_*       : default latency / width parameters
//   REG_ZERO    : architectural register $0
package pipe_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 16;
  localparam int DEF_CNT_W   = 5;
  localparam int DEF_PERF_W  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
  } pipe_ctl_t;

  // Normal advance: every register loads, nothing squashed.
  localparam pipe_ctl_t CTL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                       id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_write: 1'b1};
  // Data memory wait: whole front of the pipe holds.
  localparam pipe_ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_write: 1'b0, id_ex_bubble: 1'b0, ex_mem_write: 1'b0};
  // Taken branch in EX: redirect PC and squash IF and ID.
  localparam pipe_ctl_t CTL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                       id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1};
  // Hazard on the ID instruction: hold PC and IF/ID, inject a bubble into EX.
  localparam pipe_ctl_t CTL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                       id_ex_write: 1'b1, id_ex_bubble: 1'b1, ex_mem_write: 1'b1};

endpackage

// File: rtl/md_busy_tracker.sv
// rtl/md_busy_tracker.sv - MULT/DIV occupancy tracker with countdown and done pulse
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_accept    : a MULT/DIV is issued this cycle (only honoured in MD_IDLE)
//   i_is_div    : issued operation is a divide
//   o_busy      : HI/LO unit occupied (decode of registered state)
//   o_done      : one-cycle pulse, HI/LO result valid this cycle
module md_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_accept,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and countdown register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state. The countdown keeps running regardless of pipeline freezes,
  // since the multiplier/divider is not part of the stalled pipeline.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_accept) begin
          w_state_nxt = MD_RUN;
          w_cnt_nxt   = i_is_div ? DIV_CNT : MUL_CNT;
        end
      end
      MD_RUN: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = MD_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: pure decode of registered state, so glitch-free.
  always_comb begin
    o_busy = (r_state == MD_RUN);
    o_done = (r_state == MD_RUN) && (r_cnt == CNT_ONE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - prioritised stall/flush controller for the 5-stage pipeline
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   if_id_rs, if_id_rt               : source registers of the ID instruction
//   id_ex_rt, id_ex_mem_read         : destination / load flag of the EX instruction
//   id_uses_hilo                     : ID instruction is MFHI/MFLO/MTHI/MTLO
//   id_md_issue, id_md_is_div        : ID instruction is MULT/DIV (and which)
//   ex_branch_taken                  : EX branch/jump resolved taken
//   mem_req, mem_ready               : data memory handshake of the MEM stage
//   pc_write .. ex_mem_write         : pipeline-register enables / flushes
//   md_busy, md_done                 : HI/LO unit status
//   stall_count                      : saturating count of cycles with pc_write=0
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int PERF_W  = DEF_PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic [4:0]        id_ex_rt,
  input  logic              id_ex_mem_read,
  input  logic              id_uses_hilo,
  input  logic              id_md_issue,
  input  logic              id_md_is_div,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_bubble,
  output logic              ex_mem_write,
  output logic              md_busy,
  output logic              md_done,
  output logic [PERF_W-1:0] stall_count
);

  logic              w_freeze;
  logic              w_load_use;
  logic              w_hilo_hz;
  logic              w_md_accept;
  logic              w_md_busy;
  logic              w_md_done;
  pipe_ctl_t         w_ctl;
  logic [PERF_W-1:0] r_stall_cnt;

  always_comb begin
    w_freeze   = mem_req && !mem_ready;
    // $0 is hard-wired zero, so a load targeting it never creates a dependency.
    w_load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                 ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    w_hilo_hz  = w_md_busy && (id_uses_hilo || id_md_issue);
    // An issue only counts once the instruction actually leaves ID this cycle.
    w_md_accept = rst_n && id_md_issue && !w_freeze && !ex_branch_taken &&
                  !w_load_use && !w_hilo_hz;
  end

  // Priority: freeze > taken branch > ID hazard > run. A branch squashes the
  // ID instruction, so its hazards no longer matter.
  always_comb begin
    w_ctl = CTL_RUN;
    if (!rst_n) begin
      w_ctl = CTL_RUN;
    end else if (w_freeze) begin
      w_ctl = CTL_FREEZE;
    end else if (ex_branch_taken) begin
      w_ctl = CTL_FLUSH;
    end else if (w_load_use || w_hilo_hz) begin
      w_ctl = CTL_STALL;
    end
  end

  md_busy_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_busy_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_md_accept),
    .i_is_div (id_md_is_div),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done)
  );

  // Stall-cycle performance counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!w_ctl.pc_write && (r_stall_cnt != {PERF_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  always_comb begin
    pc_write     = w_ctl.pc_write;
    if_id_write  = w_ctl.if_id_write;
    if_id_flush  = w_ctl.if_id_flush;
    id_ex_write  = w_ctl.id_ex_write;
    id_ex_bubble = w_ctl.id_ex_bubble;
    ex_mem_write = w_ctl.ex_mem_write;
    md_busy      = w_md_busy;
    md_done      = w_md_done;
    stall_count  = r_stall_cnt;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It combines load-use detection, a multi-cycle MULT/DIV busy tracker and HI/LO interlock, EX-stage taken-branch flush, and data-memory wait freeze. The result is one prioritised set of pipeline-register enables and flushes. It sits beside the ID stage and drives PC, IF/ID, ID/EX and EX/MEM register control.

Parameters:
MUL_LAT, 4, cycles a MULT/MULTU occupies the HI/LO unit after issue (must be ≥ 1).
DIV_LAT, 16, cycles a DIV/DIVU occupies the HI/LO unit after issue (must be ≥ 1).
CNT_W, 5, width of the busy countdown; must hold max(MUL_LAT, DIV_LAT).
PERF_W, 16, width of the stall-cycle performance counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
if_id_rs  in  5  rs field of instruction in ID
if_id_rt  in  5  rt field of instruction in ID
id_ex_rt  in  5  rt (load destination) of instruction in EX
id_ex_mem_read  in  1  instruction in EX is a load
id_uses_hilo  in  1  instruction in ID is MFHI/MFLO/MTHI/MTLO
id_md_issue  in  1  instruction in ID is MULT/MULTU/DIV/DIVU
id_md_is_div  in  1  qualifies id_md_issue: 1=divide, 0=multiply
ex_branch_taken  in  1  branch/jump in EX resolved taken
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_write  out  1  ID/EX register enable
id_ex_bubble  out  1  ID/EX loads zeroed controls (bubble)
ex_mem_write  out  1  EX/MEM register enable
md_busy  out  1  HI/LO unit occupied
md_done  out  1  one-cycle pulse: HI/LO result valid this cycle
stall_count  out  PERF_W  saturating count of cycles with pc_write=0

Behaviour:
- Conditions (combinational):
  - freeze = mem_req & ~mem_ready.
  - load_use = id_ex_mem_read & id_ex_rt!=0 & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
  - hilo_hz = md_busy & (id_uses_hilo | id_md_issue).
- Priority, highest first; outputs are combinational from these and registered state:
  1. freeze: pc_write=if_id_write=id_ex_write=ex_mem_write=0, flushes/bubble=0.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1, all writes=1. This overrides load_use and hilo_hz because the ID instruction is squashed.
  3. load_use | hilo_hz: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=ex_mem_write=1.
  4. otherwise: all writes=1, flushes/bubble=0.
- MD tracker, a two-state FSM with states MD_IDLE and MD_RUN plus a CNT_W countdown:
  - md_accept = id_md_issue & ~freeze & ~ex_branch_taken & ~load_use & ~hilo_hz.
  - MD_IDLE, md_accept: load count with DIV_LAT if id_md_is_div else MUL_LAT; next state MD_RUN.
  - MD_RUN: decrement every cycle, including during freeze (the unit runs independently). At count==1, pulse md_done, go to MD_IDLE, count becomes 0.
  - md_busy = (state==MD_RUN), registered. An issue is accepted in the cycle after md_done at the earliest, because hilo_hz blocks issue while busy.
  - A new md_accept is impossible in MD_RUN; hilo_hz guarantees this.
- stall_count increments when pc_write==0 and saturates at all-ones (no wrap).
- Synchronous reset (rst_n=0 at an edge): state=MD_IDLE, count=0, md_busy=0, md_done=0, stall_count=0.
  - While rst_n is low, combinational outputs are forced: all writes=1, flushes/bubble=0.
  - Reset mid-operation abandons any MULT/DIV in progress; no md_done is produced.
- Register $0 never causes a load-use stall.

Decomposition:
- Shared package pipe_ctrl_pkg holds the MD state encoding (MD_IDLE=0, MD_RUN=1), the default latency constants, and REG_ZERO=5'd0.
- One natural sub-module, md_busy_tracker, holds the FSM, countdown and md_done pulse. The priority logic and perf counter stay in the top.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 → pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle. Repeat with id_ex_rt=0 → no stall.
- MULT then MFHI: accepted MULT (MUL_LAT=4), then id_uses_hilo=1 → md_busy high 4 cycles, stall 4 cycles, md_done pulses on the 4th, MFHI proceeds the next cycle. DIV with DIV_LAT=16 → 16-cycle stall.
- Branch vs load-use in the same cycle: ex_branch_taken=1 and load_use=1 → pc_write=1, if_id_flush=1, id_ex_bubble=1. A simultaneous id_md_issue is not accepted (md_busy stays 0).
- Memory freeze during DIV: mem_ready=0 for 3 cycles mid-divide → all writes 0 for those 3 cycles. Countdown continues; md_done occurs exactly 16 cycles after issue.
- Reset mid-DIV: rst_n=0 one cycle at count=7 → md_busy=0 next cycle, no md_done, stall_count=0.
- Perf saturation with PERF_W=4: hold freeze 20 cycles → stall_count reaches 15 and holds.
